// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, instruction
// classes, opcode/funct fields, ALU operation codes and next-PC selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC_R  = 4'd2,
    ST_EXEC_I  = 4'd3,
    ST_ALU_WB  = 4'd4,
    ST_MEM_ADR = 4'd5,
    ST_MEM_RD  = 4'd6,
    ST_MEM_WB  = 4'd7,
    ST_MEM_WR  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JUMP    = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5
  } insn_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_insn_class_dec.sv
// Combinational op/funct decoder: instruction class, R-type ALU operation and
// an illegal flag for any encoding outside the supported subset.
module insn_class_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic [3:0] alu_op,
  output logic       illegal
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    cls     = CLS_R;
    alu_op  = ALU_NOP;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/write-back,
// drives all datapath strobes and next-PC select, and stalls on mem_ready.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write,
  output logic [1:0] npc_op,
  output logic       ir_write,
  output logic       reg_write,
  output logic       rf_dst,
  output logic       wd_sel,
  output logic       alu_srcb,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       timeout
);

  localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

  state_e      state;
  insn_class_e cls;
  logic [3:0]  r_alu_op;
  logic [CW-1:0] wait_cnt;

  logic [2:0] dec_cls;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;
  logic       waiting;
  logic       expired;

  insn_class_dec u_dec (
    .op      (op),
    .funct   (funct),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  assign waiting = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
  // mem_ready in the final wait cycle wins over the timeout.
  assign expired = waiting && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      cls      <= CLS_R;
      r_alu_op <= ALU_NOP;
    end else begin
      if (waiting && !mem_ready && !expired) wait_cnt <= wait_cnt + CW'(1);
      else                                   wait_cnt <= '0;

      case (state)
        ST_FETCH:   if (mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          cls      <= insn_class_e'(dec_cls);
          r_alu_op <= dec_alu_op;
          if (dec_illegal) state <= ST_FETCH;
          else begin
            case (insn_class_e'(dec_cls))
              CLS_R:          state <= ST_EXEC_R;
              CLS_ADDI:       state <= ST_EXEC_I;
              CLS_LW, CLS_SW: state <= ST_MEM_ADR;
              CLS_BEQ:        state <= ST_BRANCH;
              CLS_J:          state <= ST_JUMP;
              default:        state <= ST_FETCH;
            endcase
          end
        end
        ST_EXEC_R, ST_EXEC_I: state <= ST_ALU_WB;
        ST_MEM_ADR: state <= (cls == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD: begin
          if (mem_ready)    state <= ST_MEM_WB;
          else if (expired) state <= ST_FETCH;
        end
        ST_MEM_WR:  if (mem_ready || expired) state <= ST_FETCH;
        default:    state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    npc_op     = NPC_PLUS4;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    rf_dst     = 1'b0;
    wd_sel     = 1'b0;
    alu_srcb   = 1'b0;
    alu_op     = ALU_NOP;
    instr_done = 1'b0;
    illegal    = 1'b0;
    timeout    = 1'b0;
    if (rstn) begin
      case (state)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          timeout  = expired;
        end
        ST_DECODE:  illegal = dec_illegal;
        ST_EXEC_R:  alu_op = r_alu_op;
        ST_EXEC_I, ST_MEM_ADR: begin
          alu_op   = ALU_ADD;
          alu_srcb = 1'b1;
        end
        ST_ALU_WB: begin
          reg_write  = 1'b1;
          rf_dst     = (cls == CLS_R);
          instr_done = 1'b1;
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          timeout  = expired;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          wd_sel     = 1'b1;
          instr_done = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write  = 1'b1;
          instr_done = mem_ready;
          timeout    = expired;
        end
        ST_BRANCH: begin
          alu_op     = ALU_SUB;
          npc_op     = NPC_BRANCH;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        ST_JUMP: begin
          npc_op     = NPC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push the
// expected retire/illegal/timeout record, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic [1:0] rstn_v = 2'b00;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  wire [1:0] mem_read_s, mem_write_s, pc_write_s, ir_write_s, reg_write_s;
  wire [1:0] rf_dst_s, wd_sel_s, alu_srcb_s, done_s, illegal_s, timeout_s;
  wire [1:0] npc_s [2];
  wire [3:0] alu_s [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // dut 0 uses the default timeout, dut 1 a short one; only one is out of reset at a time.
  multicycle_ctrl u_dut0 (
    .clk(clk), .rstn(rstn_v[0]), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read_s[0]), .mem_write(mem_write_s[0]), .pc_write(pc_write_s[0]),
    .npc_op(npc_s[0]), .ir_write(ir_write_s[0]), .reg_write(reg_write_s[0]),
    .rf_dst(rf_dst_s[0]), .wd_sel(wd_sel_s[0]), .alu_srcb(alu_srcb_s[0]), .alu_op(alu_s[0]),
    .instr_done(done_s[0]), .illegal(illegal_s[0]), .timeout(timeout_s[0])
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) u_dut1 (
    .clk(clk), .rstn(rstn_v[1]), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read_s[1]), .mem_write(mem_write_s[1]), .pc_write(pc_write_s[1]),
    .npc_op(npc_s[1]), .ir_write(ir_write_s[1]), .reg_write(reg_write_s[1]),
    .rf_dst(rf_dst_s[1]), .wd_sel(wd_sel_s[1]), .alu_srcb(alu_srcb_s[1]), .alu_op(alu_s[1]),
    .instr_done(done_s[1]), .illegal(illegal_s[1]), .timeout(timeout_s[1])
  );

  // kind: 0 = instr_done, 1 = illegal, 2 = timeout
  typedef struct {
    int         dut;
    int         kind;
    int         lat;
    int         rd;
    int         wr;
    int         regw;
    int         irw;
    int         pcw;
    logic       rf;
    logic       wd;
    logic [1:0] npc;
    logic [3:0] alu;
    logic       srcb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int         acc_lat [2];
  int         acc_rd  [2];
  int         acc_wr  [2];
  int         acc_reg [2];
  int         acc_irw [2];
  int         acc_pcw [2];
  logic [3:0] acc_alu [2];
  logic       acc_srcb[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int dut, input int kind, input int lat, input int rd, input int wr,
                      input int regw, input int irw, input int pcw, input logic rf, input logic wd,
                      input logic [1:0] npc, input logic [3:0] alu, input logic srcb);
    exp_t e;
    e.dut = dut; e.kind = kind; e.lat = lat; e.rd = rd; e.wr = wr; e.regw = regw;
    e.irw = irw; e.pcw = pcw; e.rf = rf; e.wd = wd; e.npc = npc; e.alu = alu; e.srcb = srcb;
    sb.push_back(e);
  endtask

  task automatic clear_acc(input int d);
    acc_lat[d] = 0; acc_rd[d] = 0; acc_wr[d] = 0; acc_reg[d] = 0;
    acc_irw[d] = 0; acc_pcw[d] = 0; acc_alu[d] = 4'd0; acc_srcb[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn_v[d]) begin
        clear_acc(d);
      end else begin
        acc_lat[d]++;
        acc_rd[d]  += int'(mem_read_s[d]);
        acc_wr[d]  += int'(mem_write_s[d]);
        acc_reg[d] += int'(reg_write_s[d]);
        acc_irw[d] += int'(ir_write_s[d]);
        acc_pcw[d] += int'(pc_write_s[d]);
        if (alu_s[d] != 4'd0) begin
          acc_alu[d]  = alu_s[d];
          acc_srcb[d] = alu_srcb_s[d];
        end
        if (done_s[d] || illegal_s[d] || timeout_s[d]) begin
          check($sformatf("d%0d_excl", d), 32'(done_s[d]) + 32'(illegal_s[d]) + 32'(timeout_s[d]), 1);
          if (sb.size() == 0) begin
            check($sformatf("d%0d_unexpected_event", d), 1, 0);
          end else begin
            mon_e = sb.pop_front();
            check($sformatf("d%0d_dut", d), d, mon_e.dut);
            check($sformatf("d%0d_kind", d), done_s[d] ? 0 : (illegal_s[d] ? 1 : 2), mon_e.kind);
            check($sformatf("d%0d_latency", d), acc_lat[d], mon_e.lat);
            check($sformatf("d%0d_mem_read_cycles", d), acc_rd[d], mon_e.rd);
            check($sformatf("d%0d_mem_write_cycles", d), acc_wr[d], mon_e.wr);
            check($sformatf("d%0d_reg_write_count", d), acc_reg[d], mon_e.regw);
            check($sformatf("d%0d_ir_write_count", d), acc_irw[d], mon_e.irw);
            check($sformatf("d%0d_pc_write_count", d), acc_pcw[d], mon_e.pcw);
            check($sformatf("d%0d_rf_dst", d), rf_dst_s[d], mon_e.rf);
            check($sformatf("d%0d_wd_sel", d), wd_sel_s[d], mon_e.wd);
            check($sformatf("d%0d_npc_op", d), npc_s[d], mon_e.npc);
            check($sformatf("d%0d_alu_op", d), acc_alu[d], mon_e.alu);
            check($sformatf("d%0d_alu_srcb", d), acc_srcb[d], mon_e.srcb);
          end
          clear_acc(d);
        end
      end
    end
  end

  // Each call finishes the current cycle window then advances n-1 more.
  task automatic cycles(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      mem_ready = r;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut(input int d, input logic first_rdy);
    rstn_v[d] = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("d%0d_reset_strobes", d),
            {mem_read_s[d], mem_write_s[d], pc_write_s[d], ir_write_s[d], reg_write_s[d],
             done_s[d], illegal_s[d], timeout_s[d]}, 0);
      check($sformatf("d%0d_reset_npc", d), npc_s[d], 2'b00);
    end
    @(posedge clk);
    #1;
    rstn_v[d] = 1'b1;
    mem_ready = first_rdy;
    @(negedge clk);
    check($sformatf("d%0d_first_mem_read", d), mem_read_s[d], 1);
  endtask

  task automatic set_insn(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
  endtask

  logic [5:0] r_funct [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
  logic [3:0] r_alu   [4] = '{4'd2, 4'd3, 4'd4, 4'd5};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- dut 0: default timeout ----
    set_insn(6'h00, 6'h20);
    reset_dut(0, 1'b1);

    push(0, 0, 4, 1, 0, 1, 1, 1, 1'b1, 1'b0, 2'b00, 4'd1, 1'b0);  // add
    cycles(4, 1'b1);
    set_insn(6'h08, 6'h00);
    push(0, 0, 4, 1, 0, 1, 1, 1, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);  // addi
    cycles(4, 1'b1);
    set_insn(6'h23, 6'h00);
    push(0, 0, 5, 2, 0, 1, 1, 1, 1'b0, 1'b1, 2'b00, 4'd1, 1'b1);  // lw
    cycles(5, 1'b1);
    set_insn(6'h2B, 6'h00);
    push(0, 0, 4, 1, 1, 0, 1, 1, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);  // sw
    cycles(4, 1'b1);
    set_insn(6'h02, 6'h00);
    push(0, 0, 3, 1, 0, 0, 1, 2, 1'b0, 1'b0, 2'b10, 4'd0, 1'b0);  // j
    cycles(3, 1'b1);

    set_insn(6'h04, 6'h00);
    zero = 1'b1;
    push(0, 0, 3, 1, 0, 0, 1, 2, 1'b0, 1'b0, 2'b01, 4'd2, 1'b0);  // beq taken
    cycles(3, 1'b1);
    zero = 1'b0;
    push(0, 0, 3, 1, 0, 0, 1, 1, 1'b0, 1'b0, 2'b01, 4'd2, 1'b0);  // beq not taken
    cycles(3, 1'b1);

    for (int i = 0; i < 4; i++) begin
      set_insn(6'h00, r_funct[i]);
      push(0, 0, 4, 1, 0, 1, 1, 1, 1'b1, 1'b0, 2'b00, r_alu[i], 1'b0);
      cycles(4, 1'b1);
    end

    // IR changes to an illegal encoding after decode: still retires as 'or'
    set_insn(6'h00, 6'h25);
    push(0, 0, 4, 1, 0, 1, 1, 1, 1'b1, 1'b0, 2'b00, 4'd4, 1'b0);
    cycles(2, 1'b1);
    set_insn(6'h3F, 6'h00);
    cycles(2, 1'b1);

    // lw with five stall cycles in MEM_RD
    set_insn(6'h23, 6'h00);
    push(0, 0, 10, 7, 0, 1, 1, 1, 1'b0, 1'b1, 2'b00, 4'd1, 1'b1);
    cycles(3, 1'b1);
    cycles(5, 1'b0);
    cycles(2, 1'b1);

    set_insn(6'h3F, 6'h00);
    push(0, 1, 2, 1, 0, 0, 1, 1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);  // illegal
    cycles(2, 1'b1);

    // reset while sw waits in MEM_WR
    set_insn(6'h2B, 6'h00);
    cycles(3, 1'b1);
    mem_ready = 1'b0;
    @(negedge clk);
    check("d0_mem_write_before_reset", mem_write_s[0], 1);
    @(posedge clk);
    #1;
    rstn_v[0] = 1'b0;
    @(negedge clk);
    check("d0_mem_write_in_reset", mem_write_s[0], 0);
    check("d0_done_in_reset", done_s[0], 0);
    set_insn(6'h00, 6'h20);
    push(0, 0, 4, 1, 0, 1, 1, 1, 1'b1, 1'b0, 2'b00, 4'd1, 1'b0);
    @(posedge clk);
    #1;
    rstn_v[0] = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("d0_fetch_after_reset", {mem_read_s[0], ir_write_s[0]}, 2'b11);
    cycles(4, 1'b1);
    rstn_v[0] = 1'b0;

    // ---- dut 1: MEM_TIMEOUT = 4 ----
    set_insn(6'h00, 6'h20);
    reset_dut(1, 1'b0);
    push(1, 2, 4, 4, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);  // fetch timeout
    cycles(4, 1'b0);
    push(1, 0, 7, 4, 0, 1, 1, 1, 1'b1, 1'b0, 2'b00, 4'd1, 1'b0);  // ready in 4th wait cycle
    cycles(3, 1'b0);
    cycles(4, 1'b1);

    set_insn(6'h23, 6'h00);
    push(1, 2, 7, 5, 0, 0, 1, 1, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);  // MEM_RD timeout
    cycles(3, 1'b1);
    cycles(4, 1'b0);
    push(1, 0, 8, 5, 0, 1, 1, 1, 1'b0, 1'b1, 2'b00, 4'd1, 1'b1);  // ready beats timeout
    cycles(3, 1'b1);
    cycles(3, 1'b0);
    cycles(2, 1'b1);

    cycles(3, 1'b1);
    rstn_v[1] = 1'b0;
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
